intcode_io_hub: RTL and testbench
=================================

Name: intcode_io_hub

Overview:
- Parametrised, FIFO-backed, memory-mapped I/O block for the intcode CPU bus.
- Provides CHANNELS independent input queues (host→CPU) and output queues (CPU→host), each DEPTH entries deep, plus one status/control word.
- Sits on the CPU address/data bus alongside the RAM.
- Channel 0 keeps the existing port addresses: input at 0xFFFF0000, output at 0xFFFF0001.
- Raises a stall when the CPU accesses an empty input queue or a full output queue.

Parameters:
- DATA_W, 32, width of bus data and queue entries.
- ADDR_W, 32, width of the address bus.
- CHANNELS, 2, number of input/output channel pairs (legal range 1..8).
- DEPTH, 8, entries per queue (power of 2, at least 2).
- BASE, 32'hFFFF0000, base address of the register window.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- bus_addr  in  ADDR_W  CPU address bus.
- bus_wdata  in  DATA_W  CPU write data.
- bus_we  in  1  CPU write strobe (one cycle per access).
- bus_re  in  1  CPU read strobe (one cycle per access).
- bus_rdata  out  DATA_W  read data; 0 when bus_oe=0.
- bus_oe  out  1  high when bus_addr hits a readable register; the top level uses it to drive the shared tristate bus.
- bus_stall  out  1  access cannot complete this cycle; the CPU must hold the access.
- in_valid  in  CHANNELS  host push request, one bit per channel.
- in_data  in  CHANNELS*DATA_W  push data; channel c occupies bits [c*DATA_W +: DATA_W].
- in_ready  out  CHANNELS  input queue c not full.
- out_valid  out  CHANNELS  output queue c not empty.
- out_data  out  CHANNELS*DATA_W  head of each output queue (show-ahead).
- out_ready  in  CHANNELS  host pop acknowledge.
- irq  out  1  level-sensitive: any enabled input queue is non-empty.

Behaviour:
- Address map, offset = bus_addr − BASE:
  - offset 2c: IN[c]. Readable; a read pops input queue c.
  - offset 2c+1: OUT[c]. Writable; a write pushes output queue c.
  - offset 2*CHANNELS: STATUS.
  - offset 2*CHANNELS+1: IRQ_EN.
  - Addresses below BASE or above IRQ_EN: bus_oe=0, bus_stall=0, no state change.
- STATUS read value:
  - [7:0] input-queue non-empty, bit per channel.
  - [15:8] output-queue full, bit per channel.
  - [16] sticky bus_err.
  - Other bits 0.
  - Writing STATUS with bit 16 set clears bus_err. Writing STATUS never stalls.
- IRQ_EN: read/write register, bits [CHANNELS-1:0]; reset value 0.
- Reads are combinational: bus_rdata/bus_oe follow bus_addr in the same cycle. IN[c] presents the queue head (show-ahead). The pop happens on the rising edge where bus_re=1 and the queue is non-empty.
- Writes: the OUT[c] push happens on the rising edge where bus_we=1 and the queue is not full.
- bus_stall (combinational):
  - high when bus_re=1 on an empty IN[c];
  - high when bus_we=1 on a full OUT[c];
  - no queue change while stalled.
- Illegal accesses set bus_err at the clock edge, with no other effect:
  - write to IN[c];
  - read of OUT[c];
  - bus_re and bus_we both high (neither performed).
- Host side:
  - Push accepted when in_valid[c] && in_ready[c].
  - Pop when out_valid[c] && out_ready[c].
  - in_ready and out_valid derive from registered occupancy counts (0..DEPTH, width clog2(DEPTH)+1).
- Simultaneous events on one queue:
  - push and pop together: both take effect, count unchanged, pointers each advance.
  - A full input queue does not accept a host push even if the CPU pops in the same cycle (in_ready already low).
  - An empty output queue does not present the CPU's same-cycle push to the host until the next cycle.
- Pointers wrap modulo DEPTH. Data order is strictly FIFO per channel, and channels are fully independent.
- irq = |(in_nonempty & IRQ_EN), combinational from registered state.
- Reset (asynchronous, any time, including mid-access) clears all of the following. Queue storage contents need not be reset.
  - pointers and counts;
  - bus_err and IRQ_EN;
  - as a result: in_ready = all ones, out_valid = 0, irq = 0, bus_stall = 0 (absent an access), out_data = 0.

Test Plan:
- Default params. Host pushes 5, 7 on ch0. CPU reads 0xFFFF0000 twice → rdata 5 then 7, bus_oe=1, no stall. Third read → bus_stall=1 until the host pushes 9, then rdata=9.
- CPU writes 1..8 to 0xFFFF0003 (OUT[1]) with out_ready=0 → out_valid[1]=1, in order; 9th write stalls. Host pulses out_ready once → head was 1, the stalled write of 9 completes next edge, and the queue then drains 2..9 in order.
- Input queue ch1 full (8 entries) with the CPU popping and the host pushing in the same cycle → pop returns the oldest value, push rejected, in_ready[1] goes high afterwards.
- Write to 0xFFFF0000 → STATUS reads bit16=1. Write STATUS with 0x10000 → bit16=0. STATUS with ch0 in non-empty and OUT[1] full reads 0x0201.
- IRQ_EN=0b10, push on ch0 → irq=0; push on ch1 → irq=1; CPU pops ch1 → irq=0.
- Assert reset mid-stream with queues partially full → in_ready=all ones, out_valid=0, STATUS=0, irq=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/intcode_io_hub.sv
// Memory-mapped I/O hub for the intcode CPU bus: per-channel input/output FIFOs,
// a status word and an interrupt-enable register, with bus stall on empty/full access.
module intcode_io_hub #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       CHANNELS = 2,
  parameter int unsigned       DEPTH    = 8,
  parameter logic [ADDR_W-1:0] BASE     = ADDR_W'(32'hFFFF0000)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            bus_addr,
  input  logic [DATA_W-1:0]            bus_wdata,
  input  logic                         bus_we,
  input  logic                         bus_re,
  output logic [DATA_W-1:0]            bus_rdata,
  output logic                         bus_oe,
  output logic                         bus_stall,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [CHANNELS-1:0]          out_valid,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  input  logic [CHANNELS-1:0]          out_ready,
  output logic                         irq
);

  localparam int unsigned       PW   = $clog2(DEPTH);
  localparam int unsigned       CW   = PW + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(2 * CHANNELS + 1);

  logic [ADDR_W-1:0]               offset;
  logic                            in_window;
  logic [CHANNELS-1:0]             hit_in, hit_out;
  logic                            hit_status, hit_irq_en;
  logic                            rd, wr, illegal;
  logic [CHANNELS-1:0]             in_nonempty, out_full;
  logic [CHANNELS-1:0]             cpu_pop, cpu_push, host_push, host_pop;
  logic [CHANNELS-1:0][DATA_W-1:0] in_head;
  logic [CHANNELS-1:0]             irq_en_q;
  logic                            bus_err_q;
  logic [DATA_W-1:0]               status;

  assign offset    = bus_addr - BASE;
  assign in_window = (bus_addr >= BASE) && (offset <= LAST);

  always_comb begin
    hit_in  = '0;
    hit_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit_in[c]  = in_window && (offset == ADDR_W'(2 * c));
      hit_out[c] = in_window && (offset == ADDR_W'(2 * c + 1));
    end
    hit_status = in_window && (offset == ADDR_W'(2 * CHANNELS));
    hit_irq_en = in_window && (offset == LAST);
  end

  // An access with both strobes high is illegal and performs neither side.
  assign rd      = bus_re & ~bus_we;
  assign wr      = bus_we & ~bus_re;
  assign illegal = in_window & ((bus_re & bus_we) | (bus_we & |hit_in) | (bus_re & |hit_out));

  assign cpu_pop   = {CHANNELS{rd}} & hit_in & in_nonempty;
  assign cpu_push  = {CHANNELS{wr}} & hit_out & ~out_full;
  assign host_push = in_valid & in_ready;
  assign host_pop  = out_valid & out_ready;

  assign bus_stall = (rd & |(hit_in & ~in_nonempty)) | (wr & |(hit_out & out_full));
  assign irq       = |(in_nonempty & irq_en_q);

  always_comb begin
    status                 = '0;
    status[CHANNELS-1:0]   = in_nonempty;
    status[8 +: CHANNELS]  = out_full;
    status[16]             = bus_err_q;
  end

  always_comb begin
    bus_rdata = '0;
    bus_oe    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (hit_in[c]) begin
        bus_oe    = 1'b1;
        bus_rdata = in_head[c];
      end
    end
    if (hit_status) begin
      bus_oe    = 1'b1;
      bus_rdata = status;
    end
    if (hit_irq_en) begin
      bus_oe    = 1'b1;
      bus_rdata = DATA_W'(irq_en_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_err_q <= 1'b0;
      irq_en_q  <= '0;
    end else begin
      if (illegal) begin
        bus_err_q <= 1'b1;
      end else if (wr && hit_status && bus_wdata[16]) begin
        bus_err_q <= 1'b0;
      end
      if (wr && hit_irq_en) begin
        irq_en_q <= bus_wdata[CHANNELS-1:0];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_W-1:0] in_mem  [DEPTH];
    logic [DATA_W-1:0] out_mem [DEPTH];
    logic [PW-1:0]     in_wr_q, in_rd_q, out_wr_q, out_rd_q;
    logic [CW-1:0]     in_cnt_q, out_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        in_wr_q   <= '0;
        in_rd_q   <= '0;
        out_wr_q  <= '0;
        out_rd_q  <= '0;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (host_push[c]) in_wr_q <= in_wr_q + 1'b1;
        if (cpu_pop[c])   in_rd_q <= in_rd_q + 1'b1;
        if (cpu_push[c])  out_wr_q <= out_wr_q + 1'b1;
        if (host_pop[c])  out_rd_q <= out_rd_q + 1'b1;
        in_cnt_q  <= in_cnt_q + CW'(host_push[c]) - CW'(cpu_pop[c]);
        out_cnt_q <= out_cnt_q + CW'(cpu_push[c]) - CW'(host_pop[c]);
      end
    end

    // Storage is not reset; heads are gated by occupancy instead.
    always_ff @(posedge clock) begin
      if (host_push[c]) in_mem[in_wr_q] <= in_data[c*DATA_W +: DATA_W];
      if (cpu_push[c])  out_mem[out_wr_q] <= bus_wdata;
    end

    assign in_nonempty[c] = (in_cnt_q != '0);
    assign in_ready[c]    = (in_cnt_q != CW'(DEPTH));
    assign out_valid[c]   = (out_cnt_q != '0);
    assign out_full[c]    = (out_cnt_q == CW'(DEPTH));
    assign in_head[c]     = in_nonempty[c] ? in_mem[in_rd_q] : '0;
    assign out_data[c*DATA_W +: DATA_W] = out_valid[c] ? out_mem[out_rd_q] : '0;
  end

endmodule

// File: tb/tb_intcode_io_hub.sv
// Directed bench for intcode_io_hub: a vector table for single-cycle bus behaviour plus
// hand sequences for output-queue fill/stall, full input queue and asynchronous reset.
module tb_intcode_io_hub;

  localparam logic [31:0] IN0  = 32'hFFFF0000;
  localparam logic [31:0] OUT0 = 32'hFFFF0001;
  localparam logic [31:0] IN1  = 32'hFFFF0002;
  localparam logic [31:0] OUT1 = 32'hFFFF0003;
  localparam logic [31:0] STAT = 32'hFFFF0004;
  localparam logic [31:0] IEN  = 32'hFFFF0005;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_oe;
  logic        bus_stall;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_ready = '0;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  intcode_io_hub dut (
    .clock     (clock),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_oe    (bus_oe),
    .bus_stall (bus_stall),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [1:0]  iv;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] exp_rdata;
    logic        exp_oe;
    logic        exp_stall;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic [31:0] addr, logic [31:0] wdata, logic we, logic re,
                             logic [1:0] iv, logic [31:0] d0, logic [31:0] d1,
                             logic [31:0] er, logic eo, logic es, logic ei);
    vec_t r;
    r.addr = addr; r.wdata = wdata; r.we = we; r.re = re; r.iv = iv; r.d0 = d0; r.d1 = d1;
    r.exp_rdata = er; r.exp_oe = eo; r.exp_stall = es; r.exp_irq = ei;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    in_valid = '0; out_ready = '0;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re);
    bus_addr = a; bus_wdata = d; bus_we = we; bus_re = re;
  endtask

  initial begin
    vq.push_back(v(0,    0,       0, 0, 2'b00, 0, 0, 0,       0, 0, 0));
    vq.push_back(v(0,    0,       0, 0, 2'b01, 5, 0, 0,       0, 0, 0));
    vq.push_back(v(0,    0,       0, 0, 2'b01, 7, 0, 0,       0, 0, 0));
    vq.push_back(v(IN0,  0,       0, 1, 2'b00, 0, 0, 5,       1, 0, 0));
    vq.push_back(v(IN0,  0,       0, 1, 2'b00, 0, 0, 7,       1, 0, 0));
    vq.push_back(v(IN0,  0,       0, 1, 2'b00, 0, 0, 0,       1, 1, 0));
    vq.push_back(v(IN0,  0,       0, 1, 2'b01, 9, 0, 0,       1, 1, 0));
    vq.push_back(v(IN0,  0,       0, 1, 2'b00, 0, 0, 9,       1, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 0,       1, 0, 0));
    vq.push_back(v(IEN,  2,       1, 0, 2'b00, 0, 0, 0,       1, 0, 0));
    vq.push_back(v(IEN,  0,       0, 1, 2'b00, 0, 0, 2,       1, 0, 0));
    vq.push_back(v(0,    0,       0, 0, 2'b01, 3, 0, 0,       0, 0, 0));
    vq.push_back(v(0,    0,       0, 0, 2'b10, 0, 4, 0,       0, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 3,       1, 0, 1));
    vq.push_back(v(IN1,  0,       0, 1, 2'b00, 0, 0, 4,       1, 0, 1));
    vq.push_back(v(IN0,  0,       0, 1, 2'b00, 0, 0, 3,       1, 0, 0));
    vq.push_back(v(IN0,  32'h55,  1, 0, 2'b00, 0, 0, 0,       1, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 'h10000, 1, 0, 0));
    vq.push_back(v(STAT, 'h10000, 1, 0, 2'b00, 0, 0, 'h10000, 1, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 0,       1, 0, 0));
    vq.push_back(v(STAT, 0,       1, 1, 2'b00, 0, 0, 0,       1, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 'h10000, 1, 0, 0));
    vq.push_back(v(STAT, 'h10000, 1, 0, 2'b00, 0, 0, 'h10000, 1, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 0,       1, 0, 0));
    vq.push_back(v(OUT1, 0,       0, 1, 2'b00, 0, 0, 0,       0, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 'h10000, 1, 0, 0));
    vq.push_back(v(STAT, 'h10000, 1, 0, 2'b00, 0, 0, 'h10000, 1, 0, 0));
    vq.push_back(v(32'hFFFF0006, 'h10000, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(32'hFFFEFFFF, 0, 0, 1, 2'b00, 0, 0, 0,     0, 0, 0));
    vq.push_back(v(STAT, 0,       0, 1, 2'b00, 0, 0, 0,       1, 0, 0));

    // Reset state
    #2;
    check("reset in_ready", 64'(in_ready), 64'h3);
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data", out_data, 64'h0);
    check("reset irq", 64'(irq), 64'h0);
    step();
    step();
    reset = 1'b0;
    step();

    foreach (vq[i]) begin
      bus(vq[i].addr, vq[i].wdata, vq[i].we, vq[i].re);
      in_valid = vq[i].iv;
      in_data  = {vq[i].d1, vq[i].d0};
      #1;
      check($sformatf("vec%0d rdata", i), 64'(bus_rdata), 64'(vq[i].exp_rdata));
      check($sformatf("vec%0d oe", i), 64'(bus_oe), 64'(vq[i].exp_oe));
      check($sformatf("vec%0d stall", i), 64'(bus_stall), 64'(vq[i].exp_stall));
      check($sformatf("vec%0d irq", i), 64'(irq), 64'(vq[i].exp_irq));
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'h3);
      step();
    end
    idle();

    // OUT[1] fill, stall on full, release by a single host pop, then drain.
    in_valid = 2'b01; in_data = 64'd11;
    step();
    idle();
    for (int i = 1; i <= 8; i++) begin
      bus(OUT1, i, 1'b1, 1'b0);
      #1;
      check($sformatf("fill%0d stall", i), 64'(bus_stall), 64'h0);
      step();
      check($sformatf("fill%0d head", i), out_data[63:32], 64'd1);
    end
    bus(STAT, 0, 1'b0, 1'b1);
    #1;
    check("status full+nonempty", 64'(bus_rdata), 64'h0201);
    check("out_valid after fill", 64'(out_valid), 64'h2);
    step();
    bus(OUT1, 9, 1'b1, 1'b0);
    #1;
    check("9th write stall", 64'(bus_stall), 64'h1);
    step();
    check("9th write still stalled", 64'(bus_stall), 64'h1);
    out_ready = 2'b10;
    #1;
    check("pop head", out_data[63:32], 64'd1);
    check("stall before pop edge", 64'(bus_stall), 64'h1);
    step();
    out_ready = 2'b00;
    #1;
    check("stall released", 64'(bus_stall), 64'h0);
    check("new head", out_data[63:32], 64'd2);
    step();
    idle();
    for (int k = 2; k <= 9; k++) begin
      out_ready = 2'b10;
      #1;
      check($sformatf("drain%0d valid", k), 64'(out_valid[1]), 64'h1);
      check($sformatf("drain%0d data", k), out_data[63:32], 64'(k));
      step();
    end
    out_ready = 2'b00;
    #1;
    check("drained out_valid", 64'(out_valid), 64'h0);
    check("drained out_data", out_data, 64'h0);
    bus(IN0, 0, 1'b0, 1'b1);
    #1;
    check("ch0 pop 11", 64'(bus_rdata), 64'd11);
    step();

    // CPU push to empty OUT[0] is not visible to the host until the next cycle.
    bus(OUT0, 32'h77, 1'b1, 1'b0);
    out_ready = 2'b01;
    #1;
    check("same-cycle push hidden", 64'(out_valid), 64'h0);
    step();
    idle();
    #1;
    check("push visible", 64'(out_valid), 64'h1);
    check("push data", out_data[31:0], 64'h77);
    out_ready = 2'b01;
    step();
    out_ready = 2'b00;
    #1;
    check("out0 popped", 64'(out_valid), 64'h0);

    // Full IN[1]: CPU pop and host push in the same cycle; the push is rejected.
    for (int i = 0; i < 8; i++) begin
      in_valid = 2'b10;
      in_data  = {32'(100 + i), 32'd0};
      step();
    end
    in_valid = 2'b00;
    #1;
    check("in1 full ready", 64'(in_ready), 64'h1);
    bus(IN1, 0, 1'b0, 1'b1);
    in_valid = 2'b10;
    in_data  = {32'd200, 32'd0};
    #1;
    check("full pop oldest", 64'(bus_rdata), 64'd100);
    check("full in_ready low", 64'(in_ready[1]), 64'h0);
    step();
    in_valid = 2'b00;
    #1;
    check("in_ready after pop", 64'(in_ready), 64'h3);
    for (int k = 1; k < 8; k++) begin
      #1;
      check($sformatf("in1 read%0d", k), 64'(bus_rdata), 64'(100 + k));
      step();
    end
    #1;
    check("in1 empty (push rejected)", 64'(bus_stall), 64'h1);
    step();
    idle();

    // Asynchronous reset in the middle of traffic.
    in_valid = 2'b01; in_data = 64'd21;
    step();
    in_data = 64'd22;
    step();
    idle();
    bus(OUT1, 31, 1'b1, 1'b0);
    step();
    bus(IEN, 1, 1'b1, 1'b0);
    step();
    idle();
    #1;
    check("pre-reset irq", 64'(irq), 64'h1);
    check("pre-reset out_valid", 64'(out_valid), 64'h2);
    bus(STAT, 0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check("async rst in_ready", 64'(in_ready), 64'h3);
    check("async rst out_valid", 64'(out_valid), 64'h0);
    check("async rst status", 64'(bus_rdata), 64'h0);
    check("async rst irq", 64'(irq), 64'h0);
    check("async rst out_data", out_data, 64'h0);
    check("async rst stall", 64'(bus_stall), 64'h0);
    step();
    reset = 1'b0;
    bus(IEN, 0, 1'b0, 1'b1);
    #1;
    check("irq_en cleared", 64'(bus_rdata), 64'h0);
    bus(IN0, 0, 1'b0, 1'b1);
    #1;
    check("in0 empty after reset", 64'(bus_stall), 64'h1);
    step();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
